// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised synchronous up/down counter with parallel load,
// runtime wrap/saturate mode, registered overflow/underflow pulses and
// terminal-value decodes.
// Optional feature: define UPDOWN_COUNTER_EVT_EN to build the saturating 8-bit
// OVF/UNF event tally on EVT_CNT; otherwise EVT_CNT is tied to zero.
module updown_counter_n #(
   parameter int WIDTH = 4,
   parameter int MAX   = (2**WIDTH)-1,
   parameter int STEP  = 1
)(
   input  logic             clk,
   input  logic             CLR,
   input  logic             INR,
   input  logic             DCR,
   input  logic             LD,
   input  logic [WIDTH-1:0] DIN,
   input  logic             MODE,
   output logic [WIDTH-1:0] count,
   output logic             OVF,
   output logic             UNF,
   output logic             AT_MAX,
   output logic             AT_ZERO,
   output logic [7:0]       EVT_CNT
);

   // Everything compared at WIDTH+1 bits so sums never truncate before the test.
   localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MAX+1);
   localparam logic [WIDTH:0]   DNOFF  = (WIDTH+1)'(MAX+1-STEP);
   localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH:0]   cnt_x;
   logic [WIDTH:0]   din_x;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH-1:0] up_wrap;
   logic [WIDTH-1:0] dn_sub;
   logic [WIDTH-1:0] dn_wrap;
   logic [WIDTH-1:0] cnt_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;

   // Next count and flags from the prioritised controls (CLR handled in the register).
   always_comb begin
      cnt_x   = {1'b0, count};
      din_x   = {1'b0, DIN};
      up_sum  = cnt_x + STEP_X;
      up_wrap = WIDTH'(up_sum - MOD_X);
      dn_sub  = count - STEP_W;
      dn_wrap = WIDTH'(cnt_x + DNOFF);
      cnt_nxt = count;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      if (LD) begin
         // Out-of-range load values clamp to the terminal value.
         cnt_nxt = (din_x > MAX_X) ? MAX_W : DIN;
      end else if (INR && !DCR) begin
         // A count already above MAX also lands here, so it overflows.
         if (up_sum <= MAX_X) begin
            cnt_nxt = up_sum[WIDTH-1:0];
         end else begin
            ovf_nxt = 1'b1;
            cnt_nxt = MODE ? MAX_W : up_wrap;
         end
      end else if (DCR && !INR) begin
         // Treat an out-of-range count as an underflow too.
         if (cnt_x >= STEP_X && cnt_x <= MAX_X) begin
            cnt_nxt = dn_sub;
         end else begin
            unf_nxt = 1'b1;
            cnt_nxt = MODE ? '0 : dn_wrap;
         end
      end
   end

   // Count and one-cycle flag registers; CLR wins over every other input.
   always_ff @(posedge clk) begin
      if (CLR) begin
         count <= '0;
         OVF   <= 1'b0;
         UNF   <= 1'b0;
      end else begin
         count <= cnt_nxt;
         OVF   <= ovf_nxt;
         UNF   <= unf_nxt;
      end
   end

   // Terminal decodes straight off the count register.
   always_comb begin
      AT_MAX  = (count == MAX_W);
      AT_ZERO = (count == '0);
   end

`ifdef UPDOWN_COUNTER_EVT_EN
   logic [7:0] evt;

   // Tally moves on the same edge that raises OVF/UNF, saturating at 255.
   always_ff @(posedge clk) begin
      if (CLR)
         evt <= 8'd0;
      else if ((ovf_nxt || unf_nxt) && evt != 8'hFF)
         evt <= evt + 8'd1;
   end

   assign EVT_CNT = evt;
`else
   assign EVT_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: two instances (MAX=9/STEP=3 and defaults) share
// the stimulus; an integer-arithmetic model tracks each and is compared every
// cycle, plus hand-computed literal expectations from the directed sequence.
module tb_updown_counter_n;

   localparam int W = 4;

   typedef struct {
      int cnt;
      bit ovf;
      bit unf;
      int evt;
   } mst_t;

   logic         clk = 1'b0;
   logic         clr = 1'b1, inr = 1'b0, dcr = 1'b0, ld = 1'b0, mode = 1'b0;
   logic [W-1:0] din = '0;

   logic [W-1:0] a_cnt, b_cnt;
   logic         a_ovf, a_unf, a_amax, a_azero;
   logic         b_ovf, b_unf, b_amax, b_azero;
   logic [7:0]   a_evt, b_evt;

   int   checks = 0;
   int   failures = 0;
   bit   run = 1'b0;
   mst_t ma = '{0, 1'b0, 1'b0, 0};
   mst_t mb = '{0, 1'b0, 1'b0, 0};

   updown_counter_n #(.WIDTH(W), .MAX(9), .STEP(3)) dut_a (
      .clk(clk), .CLR(clr), .INR(inr), .DCR(dcr), .LD(ld), .DIN(din), .MODE(mode),
      .count(a_cnt), .OVF(a_ovf), .UNF(a_unf), .AT_MAX(a_amax), .AT_ZERO(a_azero),
      .EVT_CNT(a_evt));

   updown_counter_n #(.WIDTH(W)) dut_b (
      .clk(clk), .CLR(clr), .INR(inr), .DCR(dcr), .LD(ld), .DIN(din), .MODE(mode),
      .count(b_cnt), .OVF(b_ovf), .UNF(b_unf), .AT_MAX(b_amax), .AT_ZERO(b_azero),
      .EVT_CNT(b_evt));

   always #5 clk = ~clk;

   // Next model state from the rules, in plain integer arithmetic.
   function automatic mst_t nxt(mst_t s, int mx, int st);
      mst_t r;
      r = s;
      r.ovf = 1'b0;
      r.unf = 1'b0;
      if (clr) begin
         r.cnt = 0;
         r.evt = 0;
         return r;
      end
      if (ld) begin
         r.cnt = (int'(din) > mx) ? mx : int'(din);
      end else if (inr && !dcr) begin
         if (s.cnt + st <= mx) r.cnt = s.cnt + st;
         else begin
            r.ovf = 1'b1;
            r.cnt = mode ? mx : s.cnt + st - (mx + 1);
         end
      end else if (dcr && !inr) begin
         if (s.cnt - st >= 0) r.cnt = s.cnt - st;
         else begin
            r.unf = 1'b1;
            r.cnt = mode ? 0 : s.cnt + (mx + 1) - st;
         end
      end
`ifdef UPDOWN_COUNTER_EVT_EN
      if ((r.ovf || r.unf) && r.evt < 255) r.evt = r.evt + 1;
`endif
      return r;
   endfunction

   always @(posedge clk) begin
      ma <= nxt(ma, 9, 3);
      mb <= nxt(mb, 15, 1);
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (run) begin
         chk("a.count", int'(a_cnt), ma.cnt);
         chk("a.ovf", int'(a_ovf), int'(ma.ovf));
         chk("a.unf", int'(a_unf), int'(ma.unf));
         chk("a.at_max", int'(a_amax), int'(ma.cnt == 9));
         chk("a.at_zero", int'(a_azero), int'(ma.cnt == 0));
         chk("a.evt", int'(a_evt), ma.evt);
         chk("b.count", int'(b_cnt), mb.cnt);
         chk("b.ovf", int'(b_ovf), int'(mb.ovf));
         chk("b.unf", int'(b_unf), int'(mb.unf));
         chk("b.at_max", int'(b_amax), int'(mb.cnt == 15));
         chk("b.at_zero", int'(b_azero), int'(mb.cnt == 0));
         chk("b.evt", int'(b_evt), mb.evt);
      end
   end

   task automatic cyc(input logic c, input logic l, input int d,
                      input logic i, input logic dc, input logic m);
      clr  = c;
      ld   = l;
      din  = W'(d);
      inr  = i;
      dcr  = dc;
      mode = m;
      @(posedge clk);
      #1;
   endtask

   int n_ovf;
   int evt_exp;

   initial begin
      // Reset with INR held high.
      cyc(1, 0, 0, 1, 0, 0);
      run = 1'b1;
      cyc(1, 0, 0, 1, 0, 0);
      chk("rst.count", int'(a_cnt), 0);
      chk("rst.at_zero", int'(a_azero), 1);
      chk("rst.at_max", int'(a_amax), 0);
      chk("rst.ovf", int'(a_ovf), 0);
      chk("rst.evt", int'(a_evt), 0);

      // Wrap up: 8 + 3 -> 1 with a single OVF pulse.
      cyc(0, 1, 8, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("wrapup.count", int'(a_cnt), 1);
      chk("wrapup.ovf", int'(a_ovf), 1);
`ifdef UPDOWN_COUNTER_EVT_EN
      evt_exp = 1;
`else
      evt_exp = 0;
`endif
      chk("wrapup.evt", int'(a_evt), evt_exp);
      cyc(0, 0, 0, 0, 0, 0);
      chk("wrapup.ovf_drop", int'(a_ovf), 0);

      // Wrap down: 1 - 3 -> 8 with a single UNF pulse.
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("wrapdn.count", int'(a_cnt), 8);
      chk("wrapdn.unf", int'(a_unf), 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("wrapdn.unf_drop", int'(a_unf), 0);

      // Saturate up: 8 -> 9, 9, 9, OVF every cycle.
      cyc(0, 1, 8, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, 0, 1);
         chk("sat.count", int'(a_cnt), 9);
         chk("sat.ovf", int'(a_ovf), 1);
         chk("sat.at_max", int'(a_amax), 1);
      end

      // Load clamp, simultaneous INR/DCR hold, CLR priority.
      cyc(0, 1, 15, 0, 0, 1);
      chk("clamp.count", int'(a_cnt), 9);
      chk("clamp.b_count", int'(b_cnt), 15);
      cyc(0, 0, 0, 1, 1, 1);
      chk("both.count", int'(a_cnt), 9);
      chk("both.ovf", int'(a_ovf), 0);
      cyc(1, 1, 5, 1, 0, 1);
      chk("clrpri.count", int'(a_cnt), 0);

      // Saturate down at zero keeps 0 and raises UNF.
      cyc(0, 0, 0, 0, 1, 1);
      chk("satdn.count", int'(a_cnt), 0);
      chk("satdn.unf", int'(a_unf), 1);

      // Default instance: 16 INR from 0 returns to 0 with one OVF.
      cyc(1, 0, 0, 0, 0, 0);
      n_ovf = 0;
      for (int k = 0; k < 16; k++) begin
         cyc(0, 0, 0, 1, 0, 0);
         if (b_ovf) n_ovf++;
      end
      chk("full.count", int'(b_cnt), 0);
      chk("full.ovf_last", int'(b_ovf), 1);
      chk("full.n_ovf", n_ovf, 1);
      cyc(0, 0, 0, 0, 0, 0);
      run = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
